// File: rtl/pe_cluster_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_cluster_pkg                                                             |
// | Shared FSM state type, width constants and saturating add.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pe_cluster_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int c_sat_max_w     = 64;
    localparam int c_def_row_idx_w = $clog2(16);
    localparam int c_def_col_idx_w = $clog2(64);
    localparam int c_def_ch_cnt_w  = $clog2(256) + 1;

    // Operands arrive sign-extended to c_sat_max_w; the result is clamped to the
    // signed range of 'width' bits and returned sign-extended.
    function automatic logic signed [c_sat_max_w-1:0] sat_add(
        input logic signed [c_sat_max_w-1:0] a,
        input logic signed [c_sat_max_w-1:0] b,
        input int                            width
    );
        logic signed [c_sat_max_w:0] sum;
        logic signed [c_sat_max_w:0] max_v;
        logic signed [c_sat_max_w:0] min_v;
        sum   = {a[c_sat_max_w-1], a} + {b[c_sat_max_w-1], b};
        max_v = ((c_sat_max_w+1)'(1) <<< (width - 1)) - (c_sat_max_w+1)'(1);
        min_v = -((c_sat_max_w+1)'(1) <<< (width - 1));
        if (sum > max_v) begin
            return max_v[c_sat_max_w-1:0];
        end else if (sum < min_v) begin
            return min_v[c_sat_max_w-1:0];
        end
        return sum[c_sat_max_w-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_row_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psum_row_bank                                                              |
// | One PE row's accumulation buffer with column counter and drain read port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module psum_row_bank
    import pe_cluster_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int MAX_OFMAP_WIDTH = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_clear,
    input  logic                                 i_wr_en,
    input  logic                                 i_first_pass,
    input  logic [DATA_WIDTH-1:0]                i_psum,
    input  logic [$clog2(MAX_OFMAP_WIDTH):0]     i_width,
    input  logic [$clog2(MAX_OFMAP_WIDTH)-1:0]   i_rd_col,
    output logic [ACC_WIDTH-1:0]                 o_rd_data,
    output logic                                 o_row_full
);

    localparam int c_col_idx_w = $clog2(MAX_OFMAP_WIDTH);

    logic [ACC_WIDTH-1:0]     r_mem [MAX_OFMAP_WIDTH];
    logic [c_col_idx_w:0]     r_col;
    logic                     w_full;
    logic                     w_wr;
    logic [ACC_WIDTH-1:0]     w_ext;
    logic [ACC_WIDTH-1:0]     w_cur;
    logic [c_sat_max_w-1:0]   w_sum_wide;
    logic [ACC_WIDTH-1:0]     w_sum;

    assign w_full     = (r_col >= i_width);
    assign w_wr       = i_wr_en && !w_full;
    assign w_ext      = {{(ACC_WIDTH-DATA_WIDTH){i_psum[DATA_WIDTH-1]}}, i_psum};
    assign w_cur      = r_mem[r_col[c_col_idx_w-1:0]];
    assign w_sum_wide = sat_add({{(c_sat_max_w-ACC_WIDTH){w_cur[ACC_WIDTH-1]}}, w_cur},
                                {{(c_sat_max_w-ACC_WIDTH){w_ext[ACC_WIDTH-1]}}, w_ext},
                                ACC_WIDTH);
    assign w_sum      = w_sum_wide[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
        end else if (i_clear) begin
            r_col <= '0;
        end else if (w_wr) begin
            r_col <= r_col + 1'b1;
        end
    end

    // The first pass overwrites, so stale data from a previous tile never leaks in.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_col[c_col_idx_w-1:0]] <= i_first_pass ? w_ext : w_sum;
        end
    end

    assign o_rd_data  = r_mem[i_rd_col];
    assign o_row_full = w_full;

endmodule
`default_nettype wire

// File: rtl/pe_psum_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_psum_accumulator                                                        |
// | Accumulates per-row psums over channel passes, then drains ofmap values.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pe_psum_accumulator
    import pe_cluster_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ACC_WIDTH       = 32,
    parameter int MAX_ROW_NUM     = 16,
    parameter int MAX_OFMAP_WIDTH = 64,
    parameter int MAX_CHANNELS    = 256
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_start,
    input  logic [$clog2(MAX_ROW_NUM):0]           i_row_num,
    input  logic [$clog2(MAX_OFMAP_WIDTH):0]       i_ofmap_width,
    input  logic [$clog2(MAX_CHANNELS):0]          i_num_channels,
    input  logic [MAX_ROW_NUM*DATA_WIDTH-1:0]      i_psum_data,
    input  logic [MAX_ROW_NUM-1:0]                 i_psum_valid,
    output logic [ACC_WIDTH-1:0]                   o_data,
    output logic [$clog2(MAX_ROW_NUM)-1:0]         o_row,
    output logic [$clog2(MAX_OFMAP_WIDTH)-1:0]     o_col,
    output logic                                   o_valid,
    output logic                                   o_last,
    input  logic                                   i_ready,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_err
);

    localparam int c_row_idx_w = $clog2(MAX_ROW_NUM);
    localparam int c_col_idx_w = $clog2(MAX_OFMAP_WIDTH);
    localparam int c_row_cnt_w = c_row_idx_w + 1;
    localparam int c_col_cnt_w = c_col_idx_w + 1;
    localparam int c_ch_cnt_w  = $clog2(MAX_CHANNELS) + 1;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [c_row_cnt_w-1:0]   r_row_num;
    logic [c_col_cnt_w-1:0]   r_width;
    logic [c_ch_cnt_w-1:0]    r_channels;
    logic [c_ch_cnt_w-1:0]    r_pass;
    logic [c_row_idx_w-1:0]   r_drain_row;
    logic [c_col_idx_w-1:0]   r_drain_col;
    logic [ACC_WIDTH-1:0]     r_data;
    logic                     r_valid;
    logic                     r_done;
    logic                     r_err;

    logic                     w_start_ok;
    logic [MAX_ROW_NUM-1:0]   w_row_active;
    logic [MAX_ROW_NUM-1:0]   w_row_full;
    logic [MAX_ROW_NUM-1:0]   w_wr_en;
    logic [MAX_ROW_NUM-1:0]   w_overflow;
    logic [ACC_WIDTH-1:0]     w_bank_rd [MAX_ROW_NUM];
    logic                     w_pass_end;
    logic                     w_final_pass;
    logic                     w_accept;
    logic                     w_is_last;
    logic                     w_err_evt;
    logic                     w_bank_clear;
    logic [c_row_idx_w-1:0]   w_next_row;
    logic [c_col_idx_w-1:0]   w_next_col;
    logic [c_row_idx_w-1:0]   w_rd_row;
    logic [c_col_idx_w-1:0]   w_rd_col;
    logic [ACC_WIDTH-1:0]     w_rd_data;

    assign w_start_ok   = i_start && (r_state == IDLE) && (|i_row_num)
                          && (|i_ofmap_width) && (|i_num_channels);
    assign w_bank_clear = w_pass_end || w_start_ok;

    generate
        for (genvar r = 0; r < MAX_ROW_NUM; r++) begin : g_row
            assign w_row_active[r] = (c_row_cnt_w'(r) < r_row_num);
            assign w_wr_en[r]      = (r_state == ACCUM) && i_psum_valid[r] && w_row_active[r];
            assign w_overflow[r]   = w_wr_en[r] && w_row_full[r];

            psum_row_bank #(
                .DATA_WIDTH      (DATA_WIDTH),
                .ACC_WIDTH       (ACC_WIDTH),
                .MAX_OFMAP_WIDTH (MAX_OFMAP_WIDTH)
            ) u_bank (
                .clk          (clk),
                .reset        (reset),
                .i_clear      (w_bank_clear),
                .i_wr_en      (w_wr_en[r]),
                .i_first_pass (r_pass == '0),
                .i_psum       (i_psum_data[r*DATA_WIDTH +: DATA_WIDTH]),
                .i_width      (r_width),
                .i_rd_col     (w_rd_col),
                .o_rd_data    (w_bank_rd[r]),
                .o_row_full   (w_row_full[r])
            );
        end
    endgenerate

    // Inactive rows count as full so the pass closes on the active rows alone.
    assign w_pass_end   = (r_state == ACCUM) && (&(w_row_full | ~w_row_active));
    assign w_final_pass = (r_pass == r_channels - 1'b1);
    assign w_accept     = r_valid && i_ready;
    assign w_is_last    = ({1'b0, r_drain_row} == r_row_num - 1'b1)
                          && ({1'b0, r_drain_col} == r_width - 1'b1);
    assign w_err_evt    = (|w_overflow) || ((r_state == DRAIN) && (|i_psum_valid));

    always_comb begin
        w_next_row = r_drain_row;
        w_next_col = r_drain_col + 1'b1;
        if ({1'b0, r_drain_col} == r_width - 1'b1) begin
            w_next_col = '0;
            w_next_row = r_drain_row + 1'b1;
        end
    end

    // Pointer (0,0) is read on drain entry, the next beat's address thereafter.
    assign w_rd_row  = (r_state == DRAIN) ? w_next_row : '0;
    assign w_rd_col  = (r_state == DRAIN) ? w_next_col : '0;
    assign w_rd_data = w_bank_rd[w_rd_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = ACCUM;
            ACCUM:   if (w_pass_end && w_final_pass) w_next_state = DRAIN;
            DRAIN:   if (w_accept && w_is_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != IDLE);
        o_last = r_valid && w_is_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_num   <= '0;
            r_width     <= '0;
            r_channels  <= '0;
            r_pass      <= '0;
            r_drain_row <= '0;
            r_drain_col <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_row_num  <= i_row_num;
                r_width    <= i_ofmap_width;
                r_channels <= i_num_channels;
                r_pass     <= '0;
                r_err      <= 1'b0;
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
            if (w_pass_end) begin
                if (w_final_pass) begin
                    r_drain_row <= '0;
                    r_drain_col <= '0;
                    r_data      <= w_rd_data;
                    r_valid     <= 1'b1;
                end else begin
                    r_pass <= r_pass + 1'b1;
                end
            end
            if ((r_state == DRAIN) && w_accept) begin
                if (w_is_last) begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_drain_row <= w_next_row;
                    r_drain_col <= w_next_col;
                    r_data      <= w_rd_data;
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_row   = r_drain_row;
    assign o_col   = r_drain_col;
    assign o_valid = r_valid;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: doc/pe_psum_accumulator.md
Name: pe_psum_accumulator

Overview:
- Collects per-row partial sums from a PE cluster's rows.
- Accumulates them across input-channel passes in a per-row buffer.
- After the final pass, streams completed ofmap values out on a valid/ready interface.
- Sits between the PE cluster row outputs and the ofmap writeback, so rows can emit psums in the same cycle.

Parameters:
- DATA_WIDTH, 16, signed psum width from each PE row
- ACC_WIDTH, 32, signed accumulator and output width (must be > DATA_WIDTH)
- MAX_ROW_NUM, 16, number of PE row inputs
- MAX_OFMAP_WIDTH, 64, maximum psum columns per row per pass
- MAX_CHANNELS, 256, maximum input-channel passes

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_start  in  1  pulse; latches config and begins a tile
- i_row_num  in  $clog2(MAX_ROW_NUM)+1  active rows
- i_ofmap_width  in  $clog2(MAX_OFMAP_WIDTH)+1  columns per row per pass
- i_num_channels  in  $clog2(MAX_CHANNELS)+1  passes to accumulate
- i_psum_data  in  MAX_ROW_NUM x DATA_WIDTH  per-row psum
- i_psum_valid  in  MAX_ROW_NUM  per-row psum strobe (pulse)
- o_data  out  ACC_WIDTH  accumulated result
- o_row  out  $clog2(MAX_ROW_NUM)  row index of o_data
- o_col  out  $clog2(MAX_OFMAP_WIDTH)  column index of o_data
- o_valid  out  1  output beat valid
- o_last  out  1  final beat of tile
- i_ready  in  1  downstream accept
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at tile end
- o_err  out  1  sticky protocol error, cleared by i_start or reset

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Buffer contents are don't-care.
- States: IDLE -> ACCUM -> DRAIN -> IDLE.
- IDLE: i_start with all three config fields nonzero latches config, clears o_err, enters ACCUM. i_start with any zero field is ignored.
- i_start in a non-IDLE state is ignored.
- ACCUM, pass counter p (0..num_channels-1); per-row column counter c[r]:
  - Valid on row r < row_num with c[r] < width: sign-extend psum to ACC_WIDTH.
  - If p==0, write buf[r][c[r]]; otherwise buf[r][c[r]] <= sat(buf + psum).
  - Then c[r]++.
  - All rows update independently in the same cycle.
- Saturation: signed clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- Pass end: the cycle all active rows have c[r]==width:
  - Reset all c[r] to 0.
  - If p==num_channels-1, go to DRAIN with drain pointer (0,0); else p++.
  - A psum arriving on the cycle of the pass-end transition belongs to the old pass and is counted as an overflow.
- Error and drop rules:
  - Valid on row r >= row_num: ignored, no error.
  - Valid on an active row with c[r]==width: dropped, o_err set.
  - Any psum_valid during DRAIN: dropped, o_err set.
- DRAIN:
  - Presents buf[row][col] with o_row/o_col; o_valid high from the first DRAIN cycle (registered output, 1-cycle latency from entry).
  - Order is row-major: col increments first, wraps at width-1 to row+1.
  - Beat advances only on o_valid && i_ready. o_data/o_row/o_col are held stable while i_ready is low.
  - o_last is high on (row_num-1, width-1).
  - When the last beat is accepted: o_valid=0, o_done pulses next cycle, state goes to IDLE.
- Reset mid-operation: immediate return to IDLE; no o_done; the partial tile is discarded.
- Latency: psum to buffer is 1 cycle. Final pass end to first o_valid is 1 cycle.

Decomposition:
- Shared package pe_cluster_pkg:
  - state enum (IDLE/ACCUM/DRAIN)
  - sat_add function parametrised by ACC_WIDTH
  - log-width localparams
- Sub-module psum_row_bank: one per row. Holds MAX_OFMAP_WIDTH x ACC_WIDTH storage, its column counter, and sat accumulate. Exposes row_full and a combinational read port for drain.
- Top: FSM, pass counter, drain pointer, error logic.

Test Plan:
- row_num=2, width=3, channels=1; row0 {1,2,3}, row1 {4,5,6}, row1 starting 1 cycle after row0 -> outputs 1,2,3,4,5,6 with (row,col) (0,0)..(1,2); o_last on 6; o_done next cycle; o_err=0.
- Same config, channels=3, identical psums each pass, rows simultaneous -> outputs 3,6,9,12,15,18.
- ACC_WIDTH=18, row_num=1, width=1, channels=8, psum 0x7FFF each -> output 0x1FFFF (saturated). Repeat with 0x8000 -> 0x20000.
- Backpressure: i_ready toggled 1,0,0,1 during drain -> each beat held stable while ready=0; no beat lost or duplicated; o_last asserted exactly once.
- Errors: row_num=2; psum on row 3 -> ignored, o_err=0. A 4th psum on row 0 with width=3 -> dropped, o_err=1, sums unchanged. Next i_start -> o_err=0.
- Reset asserted mid-ACCUM (pass 1 of 3) -> o_busy=0 next cycle, no o_done. New i_start with channels=1 produces only the new psums.
